// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and helpers for the shared-memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // A single requester still needs a one-bit grant index.
  function automatic int core_id_w(input int num_cores);
    return (num_cores > 1) ? $clog2(num_cores) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - shared data-memory port between arbiter (master) and memory (slave)
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
);

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - combinational round-robin selector starting at ptr
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int W         = core_id_w(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [W-1:0]         ptr,
  output logic                 valid,
  output logic [W-1:0]         idx
);

  int           j;
  logic [W-1:0] jw;

  // Scan downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    jw    = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      j  = (int'(ptr) + i) % NUM_CORES;
      jw = W'(j);
      if (req[jw]) begin
        valid = 1'b1;
        idx   = jw;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of NUM_CORES onto one memory port; MEM_ARB_TIMEOUT_EN adds a BUSY timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int NUM_CORES      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_CORES-1:0]                  core_req,
  input  logic [NUM_CORES-1:0]                  core_we,
  input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0]  core_addr,
  input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0]  core_wdata,
  output logic [NUM_CORES-1:0]                  core_done,
  output logic [NUM_CORES-1:0]                  core_err,
  output logic [NUM_CORES-1:0][DATA_WIDTH-1:0]  core_rdata,
  mem_arbiter_if.master                         mem,
  output logic                                  arb_busy,
  output logic [core_id_w(NUM_CORES)-1:0]       grant_id
);

  localparam int GW = core_id_w(NUM_CORES);

  arb_state_e    state;
  logic [GW-1:0] rr_ptr;
  logic          pick_valid;
  logic [GW-1:0] pick_idx;

  rr_pick #(
    .NUM_CORES (NUM_CORES),
    .W         (GW)
  ) u_rr_pick (
    .req   (core_req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign core_err = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      arb_busy      <= 1'b0;
      core_done     <= '0;
      core_rdata    <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      core_err      <= '0;
      tmo_cnt       <= '0;
`endif
    end else begin
      core_done <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      core_err  <= '0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state         <= BUSY;
            arb_busy      <= 1'b1;
            grant_id      <= pick_idx;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= core_we[pick_idx];
            mem.mem_addr  <= core_addr[pick_idx];
            mem.mem_wdata <= core_wdata[pick_idx];
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
          end
        end
        BUSY: begin
          // done/rdata are loaded here so they are visible during RESP
          if (mem.mem_ready) begin
            mem.mem_req         <= 1'b0;
            state               <= RESP;
            core_done[grant_id] <= 1'b1;
            if (!mem.mem_we) begin
              core_rdata[grant_id] <= mem.mem_rdata;
            end
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            mem.mem_req          <= 1'b0;
            state                <= RESP;
            core_done[grant_id]  <= 1'b1;
            core_err[grant_id]   <= 1'b1;
            core_rdata[grant_id] <= '1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        RESP: begin
          state    <= IDLE;
          arb_busy <= 1'b0;
          rr_ptr   <= (grant_id == GW'(NUM_CORES - 1)) ? '0 : grant_id + GW'(1);
        end
        default: begin
          state    <= IDLE;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
